traffic_light_monitor: RTL and testbench

- Passive observer on the light outputs of the two-way traffic light controller: consumes `light_a`/`light_b` and decodes them back into per-direction phase states.
- Checks each direction's phase sequence, minimum phase durations and cross-direction safety.
- Reports faults and measured green durations to the system-level checker/status logic.
- Has no influence on the controller: pure receiver of its light interface.

---
 rtl/traffic_light_monitor.sv | 127 ++++++++++++
 tb/tb_traffic_light_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase/duration/safety monitor for a two-way traffic light
// Define MON_STICKY_EN to make the four fault flags sticky until reset.
module traffic_light_monitor #(
    parameter int CNT_W      = 16,
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_a,
    input  logic [2:0]       light_b,
    output logic             conflict,
    output logic             illegal_code,
    output logic             seq_err,
    output logic             short_phase,
    output logic [CNT_W-1:0] green_a_len,
    output logic [CNT_W-1:0] green_b_len,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] cycles_done
);

    typedef enum logic [2:0] {ST_INIT, ST_RED, ST_GREEN, ST_YELLOW, ST_BAD} state_t;

    localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y = CNT_W'(MIN_YELLOW);

    state_t           st        [2];
    state_t           dec       [2];
    logic [CNT_W-1:0] cnt       [2];
    logic             timed     [2];
    logic             fresh     [2];
    logic             chg       [2];
    logic             seq_hit   [2];
    logic             ill_hit   [2];
    logic             short_hit [2];
    logic             nonred    [2];
    logic [2:0]       code      [2];
    logic             f_conf, f_ill, f_seq, f_short, f_any;

    assign code[0] = light_a;
    assign code[1] = light_b;

    function automatic state_t decode(input logic [2:0] c);
        case (c)
            3'b100:  return ST_RED;
            3'b010:  return ST_YELLOW;
            3'b001:  return ST_GREEN;
            default: return ST_BAD;
        endcase
    endfunction

    function automatic logic legal_step(input state_t from, input state_t to);
        return (from == ST_RED    && to == ST_GREEN)  ||
               (from == ST_GREEN  && to == ST_YELLOW) ||
               (from == ST_YELLOW && to == ST_RED);
    endfunction

    // timed marks a phase observed from its first cycle; only those get duration checks
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dec[i]       = decode(code[i]);
            fresh[i]     = (st[i] == ST_INIT) || (st[i] == ST_BAD);
            chg[i]       = (dec[i] != st[i]);
            ill_hit[i]   = (dec[i] == ST_BAD);
            seq_hit[i]   = chg[i] && !fresh[i] && !ill_hit[i] && !legal_step(st[i], dec[i]);
            short_hit[i] = chg[i] && timed[i] &&
                           (((st[i] == ST_GREEN) && (cnt[i] < MIN_G)) ||
                            ((st[i] == ST_YELLOW) && (cnt[i] < MIN_Y)));
            nonred[i]    = (dec[i] != ST_RED);
        end
    end

    assign f_conf  = nonred[0] && nonred[1];
    assign f_ill   = ill_hit[0] || ill_hit[1];
    assign f_seq   = seq_hit[0] || seq_hit[1];
    assign f_short = short_hit[0] || short_hit[1];
    assign f_any   = f_conf || f_ill || f_seq || f_short;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st[i]    <= ST_INIT;
                cnt[i]   <= '0;
                timed[i] <= 1'b0;
            end
            conflict     <= 1'b0;
            illegal_code <= 1'b0;
            seq_err      <= 1'b0;
            short_phase  <= 1'b0;
            green_a_len  <= '0;
            green_b_len  <= '0;
            err_count    <= '0;
            cycles_done  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (chg[i]) begin
                    st[i]    <= dec[i];
                    cnt[i]   <= CNT_W'(1);
                    timed[i] <= !fresh[i];
                end else if (cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            if (chg[0] && st[0] == ST_GREEN)
                green_a_len <= cnt[0];
            if (chg[1] && st[1] == ST_GREEN)
                green_b_len <= cnt[1];
            if (st[0] == ST_YELLOW && dec[0] == ST_RED)
                cycles_done <= cycles_done + 1'b1;
            if (f_any && err_count != '1)
                err_count <= err_count + 1'b1;
`ifdef MON_STICKY_EN
            conflict     <= conflict     | f_conf;
            illegal_code <= illegal_code | f_ill;
            seq_err      <= seq_err      | f_seq;
            short_phase  <= short_phase  | f_short;
`else
            conflict     <= f_conf;
            illegal_code <= f_ill;
            seq_err      <= f_seq;
            short_phase  <= f_short;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, X = 3'b111;
    localparam logic [3:0] F_NONE = 4'b0000, F_CONF = 4'b1000, F_ILL = 4'b0100,
                           F_SEQ = 4'b0010, F_SHORT = 4'b0001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       light_a = R;
    logic [2:0]       light_b = R;
    logic             conflict, illegal_code, seq_err, short_phase;
    logic [CNT_W-1:0] green_a_len, green_b_len, cycles_done;
    logic [ERR_W-1:0] err_count;

    traffic_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .light_a      (light_a),
        .light_b      (light_b),
        .conflict     (conflict),
        .illegal_code (illegal_code),
        .seq_err      (seq_err),
        .short_phase  (short_phase),
        .green_a_len  (green_a_len),
        .green_b_len  (green_b_len),
        .err_count    (err_count),
        .cycles_done  (cycles_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        int         ga;
        int         gb;
        int         err;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         exp_ga = 0, exp_gb = 0, exp_err = 0, exp_cyc = 0;
    logic [3:0] sticky_acc = 4'b0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // one sample per call: drive at negedge, expectation queued, next negedge returns
    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [3:0] fl, input int n = 1);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            light_a = a;
            light_b = b;
            if (fl != 4'b0 && exp_err < 255)
                exp_err++;
            sticky_acc |= fl;
`ifdef MON_STICKY_EN
            e.flags = sticky_acc;
`else
            e.flags = fl;
`endif
            e.ga  = exp_ga;
            e.gb  = exp_gb;
            e.err = exp_err;
            e.cyc = exp_cyc;
            sb.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_flags", int'({conflict, illegal_code, seq_err, short_phase}), 0);
        chk("rst_ga", int'(green_a_len), 0);
        chk("rst_gb", int'(green_b_len), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_cyc", int'(cycles_done), 0);
        exp_ga = 0; exp_gb = 0; exp_err = 0; exp_cyc = 0;
        sticky_acc = 4'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("flags", int'({conflict, illegal_code, seq_err, short_phase}), int'(e.flags));
            chk("green_a_len", int'(green_a_len), e.ga);
            chk("green_b_len", int'(green_b_len), e.gb);
            chk("err_count", int'(err_count), e.err);
            chk("cycles_done", int'(cycles_done), e.cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // legal rotation: A then B
        step(R, R, F_NONE, 2);
        step(G, R, F_NONE, 10);
        exp_ga = 10;
        step(Y, R, F_NONE);
        step(Y, R, F_NONE, 2);
        exp_cyc = 1;
        step(R, R, F_NONE);
        step(R, G, F_NONE, 10);
        exp_gb = 10;
        step(R, Y, F_NONE);
        step(R, Y, F_NONE, 2);
        step(R, R, F_NONE);

        // skipped yellow
        step(G, R, F_NONE, 6);
        exp_ga = 6;
        step(R, R, F_SEQ);
        step(R, R, F_NONE);

        // conflict, then simultaneous seq+short on B counted once
        step(G, R, F_NONE, 4);
        step(G, G, F_CONF, 3);
        exp_ga = 7;
        exp_gb = 3;
        step(Y, R, F_SEQ | F_SHORT);
        step(Y, R, F_NONE);
        exp_cyc = 2;
        step(R, R, F_NONE);

        // illegal code on A while B green, clean recovery
        step(R, G, F_NONE, 4);
        step(X, G, F_ILL | F_CONF);
        step(R, G, F_NONE);
        exp_gb = 6;
        step(R, Y, F_NONE);
        step(R, Y, F_NONE);
        step(R, R, F_NONE);

        // short green, then exact-minimum green with a short yellow
        step(G, R, F_NONE, 2);
        exp_ga = 2;
        step(Y, R, F_SHORT);
        step(Y, R, F_NONE);
        exp_cyc = 3;
        step(R, R, F_NONE);
        step(G, R, F_NONE, 4);
        exp_ga = 4;
        step(Y, R, F_NONE);
        exp_cyc = 4;
        step(R, R, F_SHORT);

        // reset mid-green, INIT-entered yellow is not duration-checked
        step(G, R, F_NONE, 5);
        do_reset();
        step(Y, R, F_NONE);
        exp_cyc = 1;
        step(R, R, F_NONE);
        step(G, R, F_NONE, 5);
        exp_ga = 5;
        step(Y, R, F_NONE);
        step(Y, R, F_NONE);
        exp_cyc = 2;
        step(R, R, F_NONE);

        // single conflict pulse (held when sticky)
        step(G, R, F_NONE, 4);
        step(G, G, F_CONF);
        exp_ga = 5;
        exp_gb = 1;
        step(Y, R, F_SEQ | F_SHORT);
        step(Y, R, F_NONE);
        exp_cyc = 3;
        step(R, R, F_NONE);
        step(R, R, F_NONE, 2);

        chk("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
